// File: rtl/det_session_ctrl_pkg.sv
// Shared types and default sizing for the serial pattern-detection session controller.
package det_pkg;

  localparam int DEF_PAT_W = 4;
  localparam int DEF_WIN_W = 8;
  localparam int DEF_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } det_state_t;

endpackage

// File: rtl/det_session_ctrl_pattern_matcher.sv
// Overlapping serial pattern matcher: shift history, fill counter, and a registered match pulse.
module pattern_matcher
  import det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             shift,
  input  logic             din,
  input  logic [PAT_W-1:0] pattern,
  output logic             match,
  output logic             match_next
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  // Only the newest PAT_W-1 bits need storing; the oldest bit of the
  // full history would fall off on the very next shift anyway.
  logic [PAT_W-2:0]  r_tail;
  logic [FILL_W-1:0] r_fill;
  logic              r_match;
  logic [PAT_W-1:0]  w_hist_next;
  logic              w_full_next;

  assign w_hist_next = {r_tail, din};
  assign w_full_next = (r_fill >= FILL_W'(PAT_W - 1));
  assign match_next  = shift && w_full_next && (w_hist_next == pattern);
  assign match       = r_match;

  // NOTE: reset is synchronous, so rstn is absent from the sensitivity list;
  // state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_tail  <= '0;
      r_fill  <= '0;
      r_match <= 1'b0;
    end else if (clr) begin
      r_tail  <= '0;
      r_fill  <= '0;
      r_match <= 1'b0;
    end else begin
      r_match <= match_next;
      if (shift) begin
        r_tail <= w_hist_next[PAT_W-2:0];
        if (r_fill != FILL_W'(PAT_W)) begin
          r_fill <= r_fill + FILL_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/det_session_ctrl.sv
// Session controller: latches a detection job, runs the matcher over valid bits, reports count/timeout.
module det_session_ctrl
  import det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int WIN_W = DEF_WIN_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [WIN_W-1:0] win_len,
  input  logic [CNT_W-1:0] match_target,
  input  logic             din,
  input  logic             din_valid,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             hit,
  output logic [CNT_W-1:0] match_cnt
);

  det_state_t       r_state;
  logic [PAT_W-1:0] r_pattern;
  logic [WIN_W-1:0] r_win_len;
  logic [CNT_W-1:0] r_target;
  logic [WIN_W-1:0] r_bit_cnt;
  logic [CNT_W-1:0] r_match_cnt;
  logic             r_timeout;
  logic             r_busy;
  logic             r_done;

  det_state_t       w_state_next;
  logic             w_start_sess;
  logic             w_shift;
  logic             w_match_next;
  logic             w_match;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [WIN_W-1:0] w_bit_cnt_inc;
  logic             w_exit_match;
  logic             w_exit_win;

  assign w_start_sess  = (r_state == IDLE) && start;
  assign w_shift       = (r_state == RUN) && din_valid;
  assign w_cnt_inc     = (r_match_cnt == '1) ? r_match_cnt : r_match_cnt + CNT_W'(1);
  assign w_bit_cnt_inc = r_bit_cnt + WIN_W'(1);
  assign w_exit_match  = w_match_next && (w_cnt_inc == r_target);
  assign w_exit_win    = w_shift && (w_bit_cnt_inc == r_win_len);

  pattern_matcher #(
    .PAT_W (PAT_W)
  ) u_matcher (
    .clk        (clk),
    .rstn       (rstn),
    .clr        (w_start_sess),
    .shift      (w_shift),
    .din        (din),
    .pattern    (r_pattern),
    .match      (w_match),
    .match_next (w_match_next)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (match_target == '0 || win_len == '0) begin
            w_state_next = DONE;
          end else begin
            w_state_next = RUN;
          end
        end
      end
      RUN: begin
        if (w_exit_match || w_exit_win) begin
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_pattern   <= '0;
      r_win_len   <= '0;
      r_target    <= '0;
      r_bit_cnt   <= '0;
      r_match_cnt <= '0;
      r_timeout   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next == RUN);
      r_done  <= (w_state_next == DONE);

      if (w_start_sess) begin
        r_pattern   <= pattern;
        r_win_len   <= win_len;
        r_target    <= match_target;
        r_bit_cnt   <= '0;
        r_match_cnt <= '0;
        // A zero target ends successfully even when the window is also zero.
        r_timeout   <= (match_target != '0) && (win_len == '0);
      end else if (w_shift) begin
        r_bit_cnt <= w_bit_cnt_inc;
        if (w_match_next) begin
          r_match_cnt <= w_cnt_inc;
        end
        if (!w_exit_match && w_exit_win) begin
          r_timeout <= 1'b1;
        end
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign timeout   = r_timeout;
  assign hit       = w_match;
  assign match_cnt = r_match_cnt;

endmodule
